// File: rtl/mk_xsim_top.sv
// mk_xsim_top: portal hub that decodes host request messages, runs register and
// DMA commands on a 16-entry register file, and streams indication messages back.
module mk_xsim_top #(
   parameter logic [31:0] REQ_PORTAL = 32'd0,
   parameter logic [31:0] IND_PORTAL = 32'd1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        in_valid,
   input  logic [31:0] in_portal,
   input  logic [31:0] in_beat,
   output logic        in_ready,
   output logic        out_en,
   output logic [31:0] out_portal,
   output logic [31:0] out_beat,
   input  logic        dma_rdy_readrequest,
   output logic        dma_en_readrequest,
   output logic [31:0] dma_readrequest_handle,
   output logic [31:0] dma_readrequest_addr,
   input  logic        dma_rdy_readresponse,
   input  logic [31:0] dma_readresponse_data,
   output logic        dma_en_readresponse,
   output logic        dma_en_write32,
   output logic [31:0] dma_write32_handle,
   output logic [31:0] dma_write32_addr,
   output logic [31:0] dma_write32_data
);

   localparam int unsigned DW    = 32;
   localparam int unsigned LW    = 16;
   localparam int unsigned RF_N  = 16;
   localparam int unsigned RF_AW = 4;
   localparam int unsigned PAY_N = 3;
   localparam int unsigned BUF_N = 2;

   localparam logic [LW-1:0] M_SET = 16'd0;
   localparam logic [LW-1:0] M_GET = 16'd1;
   localparam logic [LW-1:0] M_RD  = 16'd2;
   localparam logic [LW-1:0] M_WR  = 16'd3;

   localparam logic [DW-1:0] IND_GET = 32'h0000_0003;
   localparam logic [DW-1:0] IND_RD  = 32'h0001_0003;
   localparam logic [DW-1:0] IND_WR  = 32'h0002_0002;
   localparam logic [DW-1:0] IND_ERR = 32'h0003_0002;

   typedef enum logic [2:0] {
      S_IDLE, S_PAYLOAD, S_EXEC, S_DMA_REQ, S_DMA_RSP, S_EMIT
   } state_t;

   state_t           state_q, state_d;
   logic [DW-1:0]    hdr_q, hdr_d;
   logic [LW-1:0]    cnt_q, cnt_d;
   logic [DW-1:0]    pay_q [PAY_N];
   logic [DW-1:0]    pay_d [PAY_N];
   logic [DW-1:0]    buf_q [BUF_N];
   logic [DW-1:0]    buf_d [BUF_N];
   logic [1:0]       rem_q, rem_d;
   logic             ready_q, ready_d;
   logic             out_en_q, out_en_d;
   logic [DW-1:0]    out_beat_q, out_beat_d;
   logic [DW-1:0]    out_portal_q;
   logic [DW-1:0]    rf_q [RF_N];
   logic             rf_we;
   logic [RF_AW-1:0] rf_waddr;
   logic [DW-1:0]    rf_wdata;

   logic [LW-1:0]    hdr_len;
   logic             hit;
   logic             is_set, is_get, is_rd, is_wr;

   // Zero-length headers count as a single word
   function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] l);
      return (l == '0) ? LW'(1) : l;
   endfunction

   assign hdr_len = eff_len(hdr_q[15:0]);
   assign hit     = in_valid && ready_q && (in_portal == REQ_PORTAL);
   assign is_set  = (hdr_q[31:16] == M_SET) && (hdr_len == LW'(3));
   assign is_get  = (hdr_q[31:16] == M_GET) && (hdr_len == LW'(2));
   assign is_rd   = (hdr_q[31:16] == M_RD)  && (hdr_len == LW'(3));
   assign is_wr   = (hdr_q[31:16] == M_WR)  && (hdr_len == LW'(4));

   // Message state register and datapath registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= S_IDLE;
         hdr_q        <= '0;
         cnt_q        <= '0;
         pay_q        <= '{default: '0};
         buf_q        <= '{default: '0};
         rem_q        <= '0;
         ready_q      <= 1'b0;
         out_en_q     <= 1'b0;
         out_beat_q   <= '0;
         out_portal_q <= '0;
      end else begin
         state_q      <= state_d;
         hdr_q        <= hdr_d;
         cnt_q        <= cnt_d;
         pay_q        <= pay_d;
         buf_q        <= buf_d;
         rem_q        <= rem_d;
         ready_q      <= ready_d;
         out_en_q     <= out_en_d;
         out_beat_q   <= out_beat_d;
         out_portal_q <= out_en_d ? IND_PORTAL : '0;
      end
   end

   // Register file, written only by setReg in EXEC
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < RF_N; i++) rf_q[i] <= '0;
      end else if (rf_we) begin
         rf_q[rf_waddr] <= rf_wdata;
      end
   end

   // Next-state, command execution and indication sequencing
   always_comb begin
      state_d    = state_q;
      hdr_d      = hdr_q;
      cnt_d      = cnt_q;
      pay_d      = pay_q;
      buf_d      = buf_q;
      rem_d      = rem_q;
      out_en_d   = 1'b0;
      out_beat_d = '0;
      rf_we      = 1'b0;
      rf_waddr   = pay_q[0][RF_AW-1:0];
      rf_wdata   = pay_q[1];

      case (state_q)
         S_IDLE: begin
            if (hit) begin
               hdr_d   = in_beat;
               cnt_d   = '0;
               state_d = (eff_len(in_beat[15:0]) > LW'(1)) ? S_PAYLOAD : S_EXEC;
            end
         end
         S_PAYLOAD: begin
            if (hit) begin
               // Only the first three payload words matter; longer bodies are discarded
               if (cnt_q == LW'(0))      pay_d[0] = in_beat;
               else if (cnt_q == LW'(1)) pay_d[1] = in_beat;
               else if (cnt_q == LW'(2)) pay_d[2] = in_beat;
               cnt_d = cnt_q + LW'(1);
               if (cnt_q + LW'(1) == hdr_len - LW'(1)) state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_set) begin
               rf_we   = 1'b1;
               state_d = S_IDLE;
            end else if (is_rd) begin
               state_d = S_DMA_REQ;
            end else begin
               out_en_d = 1'b1;
               state_d  = S_EMIT;
               if (is_get) begin
                  out_beat_d = IND_GET;
                  buf_d[0]   = pay_q[0];
                  buf_d[1]   = rf_q[pay_q[0][RF_AW-1:0]];
                  rem_d      = 2'd2;
               end else if (is_wr) begin
                  out_beat_d = IND_WR;
                  buf_d[0]   = pay_q[1];
                  rem_d      = 2'd1;
               end else begin
                  out_beat_d = IND_ERR;
                  buf_d[0]   = hdr_q;
                  rem_d      = 2'd1;
               end
            end
         end
         S_DMA_REQ: begin
            if (dma_rdy_readrequest) state_d = S_DMA_RSP;
         end
         S_DMA_RSP: begin
            if (dma_rdy_readresponse) begin
               out_en_d   = 1'b1;
               out_beat_d = IND_RD;
               buf_d[0]   = pay_q[1];
               buf_d[1]   = dma_readresponse_data;
               rem_d      = 2'd2;
               state_d    = S_EMIT;
            end
         end
         S_EMIT: begin
            if (rem_q != 2'd0) begin
               out_en_d   = 1'b1;
               out_beat_d = buf_q[0];
               buf_d[0]   = buf_q[1];
               rem_d      = rem_q - 2'd1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d == S_IDLE) || (state_d == S_PAYLOAD);
   end

   // DMA handshakes must react in the same cycle the port signals ready
   assign dma_en_readrequest     = (state_q == S_DMA_REQ) && dma_rdy_readrequest;
   assign dma_readrequest_handle = (state_q == S_DMA_REQ) ? pay_q[0] : '0;
   assign dma_readrequest_addr   = (state_q == S_DMA_REQ) ? pay_q[1] : '0;
   assign dma_en_readresponse    = (state_q == S_DMA_RSP) && dma_rdy_readresponse;
   assign dma_en_write32         = (state_q == S_EXEC) && is_wr;
   assign dma_write32_handle     = dma_en_write32 ? pay_q[0] : '0;
   assign dma_write32_addr       = dma_en_write32 ? pay_q[1] : '0;
   assign dma_write32_data       = dma_en_write32 ? pay_q[2] : '0;

   assign in_ready   = ready_q;
   assign out_en     = out_en_q;
   assign out_beat   = out_beat_q;
   assign out_portal = out_portal_q;

endmodule

// File: tb/tb_mk_xsim_top.sv
// tb_mk_xsim_top: directed and randomized message stimulus for mk_xsim_top,
// checked against a message-level model of the portal hub.
module tb_mk_xsim_top;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_portal = '0;
   logic [31:0] in_beat = '0;
   logic        in_ready, out_en;
   logic [31:0] out_portal, out_beat;
   logic        dma_rdy_readrequest, dma_en_readrequest;
   logic [31:0] dma_readrequest_handle, dma_readrequest_addr;
   logic        dma_rdy_readresponse, dma_en_readresponse;
   logic [31:0] dma_readresponse_data;
   logic        dma_en_write32;
   logic [31:0] dma_write32_handle, dma_write32_addr, dma_write32_data;

   always #5 CLK = ~CLK;

   mk_xsim_top #(.REQ_PORTAL(32'd0), .IND_PORTAL(32'd1)) dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_portal(in_portal), .in_beat(in_beat), .in_ready(in_ready),
      .out_en(out_en), .out_portal(out_portal), .out_beat(out_beat),
      .dma_rdy_readrequest(dma_rdy_readrequest), .dma_en_readrequest(dma_en_readrequest),
      .dma_readrequest_handle(dma_readrequest_handle), .dma_readrequest_addr(dma_readrequest_addr),
      .dma_rdy_readresponse(dma_rdy_readresponse), .dma_readresponse_data(dma_readresponse_data),
      .dma_en_readresponse(dma_en_readresponse), .dma_en_write32(dma_en_write32),
      .dma_write32_handle(dma_write32_handle), .dma_write32_addr(dma_write32_addr),
      .dma_write32_data(dma_write32_data)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   // DMA port behaviour: manual levels for directed steps, random levels otherwise
   logic        auto_dma = 1'b0;
   logic        rnd_req = 1'b0, rnd_rsp = 1'b0;
   logic        man_req = 1'b0, man_rsp = 1'b0;
   logic [31:0] rsp_word = '0;
   assign dma_rdy_readrequest   = auto_dma ? rnd_req : man_req;
   assign dma_rdy_readresponse  = auto_dma ? rnd_rsp : man_rsp;
   assign dma_readresponse_data = rsp_word;

   always @(negedge CLK) begin
      rnd_req <= 1'($urandom_range(0, 1));
      rnd_rsp <= 1'($urandom_range(0, 1));
   end

   // Strobe capture at the active edge
   int          n_rdreq = 0, n_rsp = 0, n_wr = 0;
   int          rdreq_cyc = 0, rsp_cyc = 0, wr_cyc = 0;
   logic [31:0] rdreq_h = '0, rdreq_a = '0, wr_h = '0, wr_a = '0, wr_d = '0;
   always @(posedge CLK) begin
      if (dma_en_readrequest) begin
         n_rdreq++; rdreq_cyc = cyc; rdreq_h = dma_readrequest_handle; rdreq_a = dma_readrequest_addr;
      end
      if (dma_en_readresponse) begin
         n_rsp++; rsp_cyc = cyc;
      end
      if (dma_en_write32) begin
         n_wr++; wr_cyc = cyc; wr_h = dma_write32_handle; wr_a = dma_write32_addr; wr_d = dma_write32_data;
      end
      cyc++;
   end

   // Indication capture
   logic [31:0] got_q[$];
   logic [31:0] got_port[$];
   int          got_cyc[$];
   logic        got_rdy[$];
   int          rd_ptr = 0;
   always @(negedge CLK) begin
      if (out_en) begin
         got_q.push_back(out_beat);
         got_port.push_back(out_portal);
         got_cyc.push_back(cyc);
         got_rdy.push_back(in_ready);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Message-level reference model
   logic [31:0] mrf [16];
   logic [31:0] msg[$];
   logic [31:0] exp_q[$];

   task automatic model_msg();
      logic [15:0] m, l;
      m = msg[0][31:16];
      l = (msg[0][15:0] == 16'd0) ? 16'd1 : msg[0][15:0];
      exp_q.delete();
      if (m == 16'd0 && l == 16'd3)      mrf[msg[1][3:0]] = msg[2];
      else if (m == 16'd1 && l == 16'd2) exp_q = {32'h0000_0003, msg[1], mrf[msg[1][3:0]]};
      else if (m == 16'd2 && l == 16'd3) exp_q = {32'h0001_0003, msg[2], rsp_word};
      else if (m == 16'd3 && l == 16'd4) exp_q = {32'h0002_0002, msg[2]};
      else                               exp_q = {32'h0003_0002, msg[0]};
   endtask

   // Present one beat from a negedge; returns at the negedge after it transferred
   task automatic send_beat(input logic [31:0] b, input logic [31:0] p, output int acc);
      int t;
      t = 0;
      in_valid = 1'b1; in_beat = b; in_portal = p;
      while (in_ready !== 1'b1 && t < 100) begin @(negedge CLK); t++; end
      if (t >= 100) chk("ready_timeout", {31'b0, in_ready}, 32'd1);
      acc = cyc;
      @(negedge CLK);
   endtask

   task automatic send_msg(input int foreign, output int acc);
      int dummy;
      for (int i = 0; i < msg.size(); i++) begin
         if (i == foreign) send_beat($urandom, 32'd5, dummy);
         send_beat(msg[i], 32'd0, acc);
      end
      in_valid = 1'b0; in_beat = '0;
   endtask

   task automatic expect_ind(input string tag, input int acc, input bit is_rd);
      int t, first;
      t = 0;
      while (got_q.size() < rd_ptr + exp_q.size() && t < 300) begin @(negedge CLK); t++; end
      first = is_rd ? rsp_cyc + 1 : acc + 2;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (rd_ptr + i < got_q.size()) begin
            chk({tag, "_beat"}, got_q[rd_ptr+i], exp_q[i]);
            chk({tag, "_portal"}, got_port[rd_ptr+i], 32'd1);
            chk({tag, "_cycle"}, got_cyc[rd_ptr+i], first + i);
            chk({tag, "_busy"}, {31'b0, got_rdy[rd_ptr+i]}, 32'd0);
         end
      end
      repeat (4) @(negedge CLK);
      chk({tag, "_count"}, got_q.size() - rd_ptr, exp_q.size());
      rd_ptr = got_q.size();
   endtask

   initial begin
      int acc, r0, s0, w0, kind, foreign;
      logic [15:0] em, el;
      for (int i = 0; i < 16; i++) mrf[i] = '0;

      // Reset held with traffic and ready DMA port
      in_valid = 1'b1; in_beat = 32'h0000_0003; man_req = 1'b1; man_rsp = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("rst_ready", {31'b0, in_ready}, 32'd0);
         chk("rst_out_en", {31'b0, out_en}, 32'd0);
         chk("rst_out", out_beat | out_portal, 32'd0);
         chk("rst_strobes", {29'b0, dma_en_readrequest, dma_en_readresponse, dma_en_write32}, 32'd0);
         chk("rst_dma_bus", dma_readrequest_addr | dma_readrequest_handle | dma_write32_addr
             | dma_write32_data | dma_write32_handle, 32'd0);
      end
      RST = 1'b0; in_valid = 1'b0; man_req = 1'b0; man_rsp = 1'b0;
      #1 chk("post_rst_ready", {31'b0, in_ready}, 32'd0);
      @(negedge CLK);

      // Register round trip, getReg immediately after setReg
      msg = {32'h0000_0003, 32'd5, 32'hDEAD_BEEF}; model_msg(); send_msg(-1, acc);
      expect_ind("setreg", acc, 1'b0);
      msg = {32'h0001_0002, 32'd5}; model_msg(); send_msg(-1, acc);
      expect_ind("getreg", acc, 1'b0);

      // Directed DMA read with stalled request and delayed response
      rsp_word = 32'h1234_5678; r0 = n_rdreq; s0 = n_rsp;
      msg = {32'h0002_0003, 32'd7, 32'h100}; model_msg(); send_msg(-1, acc);
      repeat (3) @(negedge CLK);
      man_req = 1'b1;
      #1 chk("rdreq_strobe", {31'b0, dma_en_readrequest}, 32'd1);
      chk("rdreq_handle", dma_readrequest_handle, 32'd7);
      chk("rdreq_addr", dma_readrequest_addr, 32'h100);
      @(negedge CLK); man_req = 1'b0;
      chk("rdreq_once", n_rdreq - r0, 32'd1);
      repeat (3) @(negedge CLK);
      man_rsp = 1'b1;
      #1 chk("rsp_strobe", {31'b0, dma_en_readresponse}, 32'd1);
      @(negedge CLK); man_rsp = 1'b0;
      expect_ind("dmaread", acc, 1'b1);
      chk("rsp_once", n_rsp - s0, 32'd1);

      // Directed DMA write
      w0 = n_wr;
      msg = {32'h0003_0004, 32'd2, 32'h40, 32'hCAFE}; model_msg(); send_msg(-1, acc);
      expect_ind("dmawrite", acc, 1'b0);
      chk("wr_once", n_wr - w0, 32'd1);
      chk("wr_handle", wr_h, 32'd2);
      chk("wr_addr", wr_a, 32'h40);
      chk("wr_data", wr_d, 32'hCAFE);
      chk("wr_cycle", wr_cyc, acc + 1);

      // Unknown method consumes its payload and reports the header
      msg = {32'h0009_0003, 32'd1, 32'd2}; model_msg(); send_msg(-1, acc);
      expect_ind("error", acc, 1'b0);
      msg = {32'h0001_0002, 32'd5}; model_msg(); send_msg(-1, acc);
      expect_ind("after_err", acc, 1'b0);

      // Reset in the middle of a setReg
      send_beat(32'h0000_0003, 32'd0, acc);
      send_beat(32'd3, 32'd0, acc);
      in_valid = 1'b0;
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 16; i++) mrf[i] = '0;
      repeat (3) @(negedge CLK);
      chk("no_stray", got_q.size() - rd_ptr, 32'd0);
      rd_ptr = got_q.size();
      msg = {32'h0001_0002, 32'd3}; model_msg(); send_msg(-1, acc);
      expect_ind("midrst_get3", acc, 1'b0);
      msg = {32'h0001_0002, 32'd5}; model_msg(); send_msg(-1, acc);
      expect_ind("midrst_get5", acc, 1'b0);

      // Randomized message mix with foreign-portal beats and random DMA readiness
      auto_dma = 1'b1;
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 4);
         case (kind)
            0: msg = {32'h0000_0003, $urandom, $urandom};
            1: msg = {32'h0001_0002, $urandom};
            2: begin msg = {32'h0002_0003, $urandom, $urandom}; rsp_word = $urandom; end
            3: msg = {32'h0003_0004, $urandom, $urandom, $urandom};
            default: begin
               em = 16'($urandom_range(0, 8));
               el = 16'($urandom_range(0, 5));
               if ((em == 16'd0 && el == 16'd3) || (em == 16'd1 && el == 16'd2) ||
                   (em == 16'd2 && el == 16'd3) || (em == 16'd3 && el == 16'd4))
                  em = 16'h00AB;
               msg = {{em, el}};
               for (int i = 1; i < int'(el); i++) msg.push_back($urandom);
            end
         endcase
         foreign = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, msg.size() - 1)) : -1;
         r0 = n_rdreq; w0 = n_wr;
         model_msg(); send_msg(foreign, acc);
         expect_ind("rand", acc, kind == 2);
         if (kind == 2) begin
            chk("rand_rdreq_once", n_rdreq - r0, 32'd1);
            chk("rand_rdreq_handle", rdreq_h, msg[1]);
            chk("rand_rdreq_addr", rdreq_a, msg[2]);
            chk("rand_rsp_after_req", {31'b0, rsp_cyc > rdreq_cyc}, 32'd1);
         end
         if (kind == 3) begin
            chk("rand_wr_once", n_wr - w0, 32'd1);
            chk("rand_wr_bus", wr_h ^ wr_a ^ wr_d, msg[1] ^ msg[2] ^ msg[3]);
            chk("rand_wr_cycle", wr_cyc, acc + 1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
